// File: rtl/result_checker.sv
// result_checker: in-order compare stage between the reference model and the
// scoreboard. Expected results are queued in a FIFO; each DUT result is
// compared against the oldest queued value. A mismatch or underflow raises a
// one-cycle event pulse and captures the offending pair for debug.

module result_checker #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_exp_valid,
  input  logic [WIDTH-1:0]         i_exp_data,
  output logic                     o_exp_ready,
  input  logic                     i_dut_valid,
  input  logic [WIDTH-1:0]         i_dut_data,
  output logic                     o_event,
  output logic                     o_underflow,
  output logic [$clog2(DEPTH):0]   o_fill,
  output logic [WIDTH-1:0]         o_mis_exp,
  output logic [WIDTH-1:0]         o_mis_dut
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_FILL = CW'(DEPTH);

  // Expected-result storage and its bookkeeping. The counters carry one extra
  // bit so that full and empty stay distinguishable; the pointers are simply
  // their low bits and wrap modulo DEPTH on their own.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    wr_count;
  logic [CW-1:0]    rd_count;
  logic [CW-1:0]    fill_q;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Per-cycle decode
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             underflow_hit;
  logic             mismatch;
  logic [WIDTH-1:0] head;
  logic [CW-1:0]    wr_count_nxt;
  logic [CW-1:0]    rd_count_nxt;

  assign wr_ptr = wr_count[AW-1:0];
  assign rd_ptr = rd_count[AW-1:0];

  // Ready depends only on the registered fill, never on this cycle's DUT
  // result, so a full FIFO refuses a push even when a pop happens alongside.
  assign o_exp_ready = !full;
  assign o_fill      = fill_q;

  // Decode push/pop/compare from registered state and the current inputs.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    full          = 1'b0;
    empty         = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    underflow_hit = 1'b0;
    mismatch      = 1'b0;
    head          = '0;
    wr_count_nxt  = wr_count;
    rd_count_nxt  = rd_count;

    full  = (fill_q == FULL_FILL);
    empty = (fill_q == '0);

    // No bypass: a value pushed this cycle is not visible to this cycle's
    // compare, so emptiness is judged on the registered fill alone.
    push          = i_exp_valid && !full;
    pop           = i_dut_valid && !empty;
    underflow_hit = i_dut_valid && empty;

    head     = mem[rd_ptr];
    mismatch = pop && (head != i_dut_data);

    wr_count_nxt = wr_count + CW'(push);
    rd_count_nxt = rd_count + CW'(pop);
  end

  // Write accepted expected results into the queue.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the counters define which entries
    // are live, so stale contents are never read after a reset.
    if (!reset && push) begin
      mem[wr_ptr] <= i_exp_data;
    end
  end

  // Advance the write/read counters and register the resulting occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      wr_count <= '0;
      rd_count <= '0;
      fill_q   <= '0;
    end else begin
      wr_count <= wr_count_nxt;
      rd_count <= rd_count_nxt;
      fill_q   <= wr_count_nxt - rd_count_nxt;
    end
  end

  // Raise the event pulse and capture the offending pair for debug.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_event     <= 1'b0;
      o_underflow <= 1'b0;
      o_mis_exp   <= '0;
      o_mis_dut   <= '0;
    end else begin
      o_event <= mismatch || underflow_hit;
      if (underflow_hit) begin
        o_underflow <= 1'b1;
      end
      // An underflow has no expected value, so only the DUT side is captured.
      if (mismatch) begin
        o_mis_exp <= head;
      end
      if (mismatch || underflow_hit) begin
        o_mis_dut <= i_dut_data;
      end
    end
  end

endmodule

// File: tb/tb_result_checker.sv
// Testbench for result_checker: a reference queue model predicts each cycle's
// outputs, which are pushed to a scoreboard queue when the stimulus is driven
// and popped and compared after the clock edge.

module tb_result_checker;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             i_exp_valid;
  logic [WIDTH-1:0] i_exp_data;
  logic             o_exp_ready;
  logic             i_dut_valid;
  logic [WIDTH-1:0] i_dut_data;
  logic             o_event;
  logic             o_underflow;
  logic [4:0]       o_fill;
  logic [WIDTH-1:0] o_mis_exp;
  logic [WIDTH-1:0] o_mis_dut;

  always #5 clk = ~clk;

  result_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_exp_valid (i_exp_valid),
    .i_exp_data  (i_exp_data),
    .o_exp_ready (o_exp_ready),
    .i_dut_valid (i_dut_valid),
    .i_dut_data  (i_dut_data),
    .o_event     (o_event),
    .o_underflow (o_underflow),
    .o_fill      (o_fill),
    .o_mis_exp   (o_mis_exp),
    .o_mis_dut   (o_mis_dut)
  );

  typedef struct {
    logic             ev;
    logic             uf;
    logic [WIDTH-1:0] mexp;
    logic [WIDTH-1:0] mdut;
    logic [4:0]       fill;
    logic             rdy;
  } exp_t;

  exp_t             sb_q[$];
  logic [WIDTH-1:0] mdl_q[$];
  logic             m_uf;
  logic [WIDTH-1:0] m_mexp;
  logic [WIDTH-1:0] m_mdut;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int ev_count = 0;
  int ev_last_cyc = -10;
  int ev_prev_cyc = -10;

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock of stimulus: predict the outcome, then compare after the edge.
  task automatic step(input logic ev_in, input logic [WIDTH-1:0] ed,
                      input logic dv, input logic [WIDTH-1:0] dd);
    exp_t             e;
    exp_t             g;
    logic             rdy_before;
    logic [WIDTH-1:0] hd;
    @(negedge clk);
    i_exp_valid = ev_in;
    i_exp_data  = ed;
    i_dut_valid = dv;
    i_dut_data  = dd;

    rdy_before = (mdl_q.size() < DEPTH);
    e.ev = 1'b0;
    if (dv) begin
      if (mdl_q.size() == 0) begin
        e.ev   = 1'b1;
        m_uf   = 1'b1;
        m_mdut = dd;
      end else begin
        hd = mdl_q.pop_front();
        if (hd !== dd) begin
          e.ev   = 1'b1;
          m_mexp = hd;
          m_mdut = dd;
        end
      end
    end
    if (ev_in && rdy_before) mdl_q.push_back(ed);
    e.uf   = m_uf;
    e.mexp = m_mexp;
    e.mdut = m_mdut;
    e.fill = 5'(mdl_q.size());
    e.rdy  = (mdl_q.size() != DEPTH);
    sb_q.push_back(e);

    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    check("event",     {31'd0, o_event},     {31'd0, g.ev});
    check("underflow", {31'd0, o_underflow}, {31'd0, g.uf});
    check("fill",      {27'd0, o_fill},      {27'd0, g.fill});
    check("exp_ready", {31'd0, o_exp_ready}, {31'd0, g.rdy});
    check("mis_exp",   o_mis_exp,            g.mexp);
    check("mis_dut",   o_mis_dut,            g.mdut);
    if (o_event === 1'b1) begin
      ev_count++;
      ev_prev_cyc = ev_last_cyc;
      ev_last_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, '0);
  endtask

  // Hold reset for two cycles with live inputs, which must be ignored.
  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    i_exp_valid = 1'b1;
    i_exp_data  = $urandom;
    i_dut_valid = 1'b1;
    i_dut_data  = $urandom;
    repeat (2) @(negedge clk);
    reset       = 1'b0;
    i_exp_valid = 1'b0;
    i_dut_valid = 1'b0;
    mdl_q.delete();
    sb_q.delete();
    m_uf   = 1'b0;
    m_mexp = '0;
    m_mdut = '0;
    #1;
    check("rst_fill",      {27'd0, o_fill},      32'd0);
    check("rst_exp_ready", {31'd0, o_exp_ready}, 32'd1);
    check("rst_event",     {31'd0, o_event},     32'd0);
    check("rst_underflow", {31'd0, o_underflow}, 32'd0);
    check("rst_mis_exp",   o_mis_exp,            32'd0);
    check("rst_mis_dut",   o_mis_dut,            32'd0);
  endtask

  initial begin
    int               ev_base;
    logic [WIDTH-1:0] dd;
    logic [WIDTH-1:0] bad_exp;
    logic [WIDTH-1:0] bad_dut;

    reset       = 1'b1;
    i_exp_valid = 1'b0;
    i_exp_data  = '0;
    i_dut_valid = 1'b0;
    i_dut_data  = '0;
    m_uf        = 1'b0;
    m_mexp      = '0;
    m_mdut      = '0;

    // Reset then idle
    do_reset();
    repeat (2) idle();

    // Reset mid-operation with five entries queued: the queue is discarded
    for (int i = 0; i < 5; i++) step(1'b1, 32'hA0 + i, 1'b0, '0);
    check("fill_before_reset", {27'd0, o_fill}, 32'd5);
    do_reset();
    step(1'b0, '0, 1'b1, 32'hA0);   // old head gone: must be an underflow
    idle();
    do_reset();

    // In-order match
    ev_base = ev_count;
    for (int i = 1; i <= 3; i++) step(1'b1, i, 1'b0, '0);
    for (int i = 1; i <= 3; i++) step(1'b0, '0, 1'b1, i);
    idle();
    check("match_no_events", ev_count - ev_base, 0);
    check("match_fill_end", {27'd0, o_fill}, 32'd0);

    // Single mismatch
    ev_base = ev_count;
    step(1'b1, 32'hDEADBEEF, 1'b0, '0);
    step(1'b0, '0, 1'b1, 32'hDEADBEEE);
    idle();
    idle();
    check("mismatch_event_count", ev_count - ev_base, 1);
    check("mismatch_mis_exp", o_mis_exp, 32'hDEADBEEF);
    check("mismatch_mis_dut", o_mis_dut, 32'hDEADBEEE);

    // Full, rejected push alongside a pop, then streaming across pointer wrap
    for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h100 + i, 1'b0, '0);
    check("full_fill", {27'd0, o_fill}, 32'd16);
    check("full_ready", {31'd0, o_exp_ready}, 32'd0);
    step(1'b1, 32'h999, 1'b1, mdl_q[0]);
    check("full_pop_fill", {27'd0, o_fill}, 32'd15);
    check("full_pop_ready", {31'd0, o_exp_ready}, 32'd1);
    ev_base = ev_count;
    for (int i = 0; i < 20; i++) step(1'b1, 32'h200 + i, 1'b1, mdl_q[0]);
    while (mdl_q.size() != 0) step(1'b0, '0, 1'b1, mdl_q[0]);
    idle();
    check("wrap_no_events", ev_count - ev_base, 0);
    check("wrap_fill_end", {27'd0, o_fill}, 32'd0);

    // Underflow with a simultaneous push on an empty FIFO
    ev_base = ev_count;
    step(1'b1, 32'h55, 1'b1, 32'h55);
    check("uf_fill", {27'd0, o_fill}, 32'd1);
    check("uf_mis_dut", o_mis_dut, 32'h55);
    idle();
    step(1'b0, '0, 1'b1, 32'h55);   // the queued 0x55 matches
    idle();
    check("uf_event_count", ev_count - ev_base, 1);
    check("uf_sticky", {31'd0, o_underflow}, 32'd1);

    // Streaming at fill 4 with mismatches at cycles 100 and 101
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 1'b0, '0);
    ev_base = ev_count;
    bad_exp = '0;
    bad_dut = '0;
    for (int i = 0; i < 1000; i++) begin
      dd = mdl_q[0];
      if (i == 100 || i == 101) begin
        if (i == 101) bad_exp = dd;
        dd = dd ^ (32'h1 << (i % 32));
        if (i == 101) bad_dut = dd;
      end
      step(1'b1, $urandom, 1'b1, dd);
    end
    check("stream_fill", {27'd0, o_fill}, 32'd4);
    check("stream_event_count", ev_count - ev_base, 2);
    check("stream_consecutive", ev_last_cyc - ev_prev_cyc, 1);
    check("stream_mis_exp", o_mis_exp, bad_exp);
    check("stream_mis_dut", o_mis_dut, bad_dut);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
